// File: rtl/imu_spi_serf.sv
// SPI responder emulating the inertial sensor: 16-bit frames, config registers,
// gyro/accel data registers with burst-coherent locking and a data-ready INT.
module imu_spi_serf #(
  parameter logic [7:0] WHO_AM_I = 8'h6A
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  output logic               INT,
  input  logic               smpl_vld,
  input  logic signed [15:0] pitch_rt,
  input  logic signed [15:0] roll_rt,
  input  logic signed [15:0] yaw_rt,
  input  logic signed [15:0] AX,
  input  logic signed [15:0] AY,
  input  logic signed [15:0] AZ,
  output logic [7:0]         cfg_int1,
  output logic [7:0]         cfg_xl,
  output logic [7:0]         cfg_g,
  output logic [7:0]         cfg_c14
);

  logic [1:0]       ss_sync_r, sclk_sync_r, mosi_sync_r;
  logic             ss_d_r, sclk_d_r;
  logic             ss_s, sclk_s, mosi_s;
  logic             ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s;
  logic [4:0]       bit_cnt_r;
  logic [7:0]       rx_r, tx_r;
  logic             rw_r;
  logic [6:0]       addr_r, rd_addr_s;
  logic [3:0]       rd_off_s;
  logic [7:0]       rd_data_s;
  logic [5:0][15:0] data_r, pend_r, sample_s;
  logic [11:0][7:0] data_bytes_s;
  logic             pend_vld_r, lock_r, int_flag_r;
  logic             frame_ok_s, wr_commit_s, lock_rd_s, rel_rd_s;

  assign ss_s        = ss_sync_r[1];
  assign sclk_s      = sclk_sync_r[1];
  assign mosi_s      = mosi_sync_r[1];
  assign ss_fall_s   = ~ss_s & ss_d_r;
  assign ss_rise_s   = ss_s & ~ss_d_r;
  assign sclk_rise_s = ~ss_s & sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~ss_s & ~sclk_s & sclk_d_r;

  // Index 0 is pitch, so byte k of data_bytes_s sits at address 0x22 + k.
  assign sample_s     = {AZ, AY, AX, yaw_rt, roll_rt, pitch_rt};
  assign data_bytes_s = data_r;
  assign rd_addr_s    = {rx_r[5:0], mosi_s};
  assign rd_off_s     = rd_addr_s[3:0] - 4'h2;

  assign frame_ok_s  = ss_rise_s & (bit_cnt_r == 5'd16);
  assign wr_commit_s = frame_ok_s & ~rw_r;
  assign lock_rd_s   = frame_ok_s & rw_r & (addr_r >= 7'h22) & (addr_r <= 7'h2C);
  assign rel_rd_s    = frame_ok_s & rw_r & (addr_r == 7'h2D);

  // Synchronizers and edge-detect history for the SPI pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_r   <= 2'b11;
      sclk_sync_r <= 2'b11;
      mosi_sync_r <= 2'b00;
      ss_d_r      <= 1'b1;
      sclk_d_r    <= 1'b1;
    end else begin
      ss_sync_r   <= {ss_sync_r[0], SS_n};
      sclk_sync_r <= {sclk_sync_r[0], SCLK};
      mosi_sync_r <= {mosi_sync_r[0], MOSI};
      ss_d_r      <= ss_s;
      sclk_d_r    <= sclk_s;
    end
  end

  // Register read mux, addressed by the header as it completes on the 8th rise
  always_comb begin
    rd_data_s = 8'h00;
    case (rd_addr_s)
      7'h0D:   rd_data_s = cfg_int1;
      7'h0F:   rd_data_s = WHO_AM_I;
      7'h10:   rd_data_s = cfg_xl;
      7'h11:   rd_data_s = cfg_g;
      7'h14:   rd_data_s = cfg_c14;
      default: begin
        if ((rd_addr_s >= 7'h22) && (rd_addr_s <= 7'h2D)) begin
          rd_data_s = data_bytes_s[rd_off_s];
        end else begin
          rd_data_s = 8'h00;
        end
      end
    endcase
  end

  // Shift engine: sample MOSI on rise, load response after the header byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= 5'd0;
      rx_r      <= 8'h00;
      tx_r      <= 8'h00;
      rw_r      <= 1'b0;
      addr_r    <= 7'h00;
    end else if (ss_fall_s) begin
      bit_cnt_r <= 5'd0;
      rx_r      <= 8'h00;
      tx_r      <= 8'h00;
    end else if (sclk_rise_s) begin
      rx_r <= {rx_r[6:0], mosi_s};
      if (bit_cnt_r != 5'd31) begin
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end
      if (bit_cnt_r == 5'd7) begin
        rw_r   <= rx_r[6];
        addr_r <= rd_addr_s;
        tx_r   <= rx_r[6] ? rd_data_s : 8'h00;
      end
    end else if (sclk_fall_s) begin
      tx_r <= {tx_r[6:0], 1'b0};
    end
  end

  // MISO updates on SCLK fall and idles low outside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MISO <= 1'b0;
    end else if (ss_s) begin
      MISO <= 1'b0;
    end else if (sclk_fall_s) begin
      MISO <= tx_r[7];
    end
  end

  // Configuration registers, written only by a complete 16-bit write frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_int1 <= 8'h00;
      cfg_xl   <= 8'h00;
      cfg_g    <= 8'h00;
      cfg_c14  <= 8'h00;
    end else if (wr_commit_s) begin
      case (addr_r)
        7'h0D:   cfg_int1 <= rx_r;
        7'h10:   cfg_xl   <= rx_r;
        7'h11:   cfg_g    <= rx_r;
        7'h14:   cfg_c14  <= rx_r;
        default: cfg_int1 <= cfg_int1;
      endcase
    end
  end

  // Sample path: a lock taken by a burst diverts new samples to the pending buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= {6{16'h0000}};
      pend_r     <= {6{16'h0000}};
      pend_vld_r <= 1'b0;
      lock_r     <= 1'b0;
      int_flag_r <= 1'b0;
    end else if (rel_rd_s) begin
      lock_r     <= 1'b0;
      pend_vld_r <= 1'b0;
      if (smpl_vld) begin
        data_r     <= sample_s;
        int_flag_r <= 1'b1;
      end else if (pend_vld_r) begin
        data_r     <= pend_r;
        int_flag_r <= 1'b1;
      end else begin
        int_flag_r <= 1'b0;
      end
    end else if (lock_rd_s) begin
      lock_r     <= 1'b1;
      int_flag_r <= 1'b0;
      if (smpl_vld) begin
        pend_r     <= sample_s;
        pend_vld_r <= 1'b1;
      end
    end else if (smpl_vld) begin
      if (lock_r) begin
        pend_r     <= sample_s;
        pend_vld_r <= 1'b1;
      end else begin
        data_r     <= sample_s;
        int_flag_r <= 1'b1;
      end
    end
  end

  // Registered interrupt output, masked by INT1_CTRL bit 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      INT <= 1'b0;
    end else begin
      INT <= int_flag_r & cfg_int1[1];
    end
  end

endmodule

// File: tb/tb_imu_spi_serf.sv
// Self-checking bench for imu_spi_serf: bit-banged SPI frames, random samples,
// and a register-level reference model of config, data, lock and INT.
module tb_imu_spi_serf;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, SCLK, MOSI, smpl_vld;
  logic [15:0] smp [6];
  logic        MISO, INT;
  logic [7:0]  cfg_int1, cfg_xl, cfg_g, cfg_c14;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [7:0]  mc_int1, mc_xl, mc_g, mc_c14;
  logic [15:0] m_data [6];
  logic [15:0] m_pend [6];
  bit          m_pend_vld, m_lock, m_flag;

  always #5 clk = ~clk;

  imu_spi_serf dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .smpl_vld(smpl_vld),
    .pitch_rt(smp[0]), .roll_rt(smp[1]), .yaw_rt(smp[2]),
    .AX(smp[3]), .AY(smp[4]), .AZ(smp[5]),
    .cfg_int1(cfg_int1), .cfg_xl(cfg_xl), .cfg_g(cfg_g), .cfg_c14(cfg_c14)
  );

  task automatic m_reset();
    mc_int1 = 8'h00; mc_xl = 8'h00; mc_g = 8'h00; mc_c14 = 8'h00;
    for (int i = 0; i < 6; i++) begin
      m_data[i] = 16'h0000;
      m_pend[i] = 16'h0000;
    end
    m_pend_vld = 1'b0; m_lock = 1'b0; m_flag = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    int k;
    if (a == 7'h0D) return mc_int1;
    if (a == 7'h0F) return 8'h6A;
    if (a == 7'h10) return mc_xl;
    if (a == 7'h11) return mc_g;
    if (a == 7'h14) return mc_c14;
    if (a >= 7'h22 && a <= 7'h2D) begin
      k = int'(a) - 34;
      return (k % 2 == 1) ? m_data[k / 2][15:8] : m_data[k / 2][7:0];
    end
    return 8'h00;
  endfunction

  function automatic logic m_int();
    return m_flag && mc_int1[1];
  endfunction

  task automatic m_commit(input logic [15:0] cmd);
    logic [6:0] a;
    a = cmd[14:8];
    if (!cmd[15]) begin
      if (a == 7'h0D) mc_int1 = cmd[7:0];
      if (a == 7'h10) mc_xl   = cmd[7:0];
      if (a == 7'h11) mc_g    = cmd[7:0];
      if (a == 7'h14) mc_c14  = cmd[7:0];
    end else if (a >= 7'h22 && a <= 7'h2C) begin
      m_flag = 1'b0;
      m_lock = 1'b1;
    end else if (a == 7'h2D) begin
      m_flag = 1'b0;
      m_lock = 1'b0;
      if (m_pend_vld) begin
        m_data = m_pend;
        m_flag = 1'b1;
        m_pend_vld = 1'b0;
      end
    end
  endtask

  // Bit-bang one frame with nrise SCLK rises; resp collects MISO before each rise.
  task automatic spi_frame(input logic [15:0] cmd, input int nrise, output logic [15:0] resp);
    resp = 16'h0000;
    @(negedge clk); SS_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0; MOSI = cmd[15 - i];
      repeat (5) @(negedge clk);
      resp[15 - i] = MISO;
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
    end
    SS_n = 1'b1; MOSI = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] cmd, output logic [15:0] resp);
    spi_frame(cmd, 16, resp);
    m_commit(cmd);
  endtask

  task automatic do_sample(input logic [15:0] p, r, y, ax, ay, az);
    @(negedge clk);
    smp[0] = p; smp[1] = r; smp[2] = y; smp[3] = ax; smp[4] = ay; smp[5] = az;
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    if (m_lock) begin
      m_pend[0] = p; m_pend[1] = r; m_pend[2] = y; m_pend[3] = ax; m_pend[4] = ay; m_pend[5] = az;
      m_pend_vld = 1'b1;
    end else begin
      m_data[0] = p; m_data[1] = r; m_data[2] = y; m_data[3] = ax; m_data[4] = ay; m_data[5] = az;
      m_flag = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; smpl_vld = 1'b0;
    for (int i = 0; i < 6; i++) smp[i] = 16'h0000;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({INT, MISO} !== 2'b00) $display("FAIL reset_int_miso: got %b want 00", {INT, MISO});
    else n_pass++;
    n_total++;
    if ({cfg_int1, cfg_xl, cfg_g, cfg_c14} !== 32'h0)
      $display("FAIL reset_cfg: got %h want 00000000", {cfg_int1, cfg_xl, cfg_g, cfg_c14});
    else n_pass++;
  endtask

  task automatic test_config();
    logic [15:0] resp;
    logic [7:0]  v [4];
    logic [6:0]  adr [4];
    logic [7:0]  exp;
    adr[0] = 7'h0D; adr[1] = 7'h10; adr[2] = 7'h11; adr[3] = 7'h14;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        v[0] = 8'h02; v[1] = 8'h53; v[2] = 8'h50; v[3] = 8'h60;
      end else begin
        for (int j = 0; j < 4; j++) v[j] = 8'($urandom_range(0, 255));
      end
      for (int j = 0; j < 4; j++) frame({1'b0, adr[j], v[j]}, resp);
      n_total++;
      if ({cfg_int1, cfg_xl, cfg_g, cfg_c14} !== {mc_int1, mc_xl, mc_g, mc_c14})
        $display("FAIL cfg_outputs: got %h want %h", {cfg_int1, cfg_xl, cfg_g, cfg_c14},
                 {mc_int1, mc_xl, mc_g, mc_c14});
      else n_pass++;
      for (int j = 0; j < 4; j++) begin
        exp = m_read(adr[j]);
        frame({1'b1, adr[j], 8'h00}, resp);
        n_total++;
        if (resp !== {8'h00, exp}) $display("FAIL cfg_readback %h: got %h want %h", adr[j], resp, {8'h00, exp});
        else n_pass++;
      end
      n_total++;
      if (INT !== m_int()) $display("FAIL cfg_int: got %b want %b", INT, m_int());
      else n_pass++;
    end
    frame(16'h0D02, resp);
  endtask

  task automatic test_whoami();
    logic [15:0] resp;
    logic [6:0]  a;
    logic [7:0]  exp;
    frame(16'h8F00, resp);
    n_total++;
    if (resp !== 16'h006A) $display("FAIL whoami: got %h want 006a", resp);
    else n_pass++;
    frame(16'h0F55, resp);
    frame(16'h8F00, resp);
    n_total++;
    if (resp !== 16'h006A) $display("FAIL whoami_ro: got %h want 006a", resp);
    else n_pass++;
    for (int it = 0; it < 4; it++) begin
      a = (it == 0) ? 7'h7F : 7'($urandom_range(46, 127));
      frame({1'b0, a, 8'($urandom_range(1, 255))}, resp);
      exp = m_read(a);
      frame({1'b1, a, 8'h00}, resp);
      n_total++;
      if (resp !== {8'h00, exp}) $display("FAIL unmapped %h: got %h want %h", a, resp, {8'h00, exp});
      else n_pass++;
    end
  endtask

  task automatic test_burst();
    logic [15:0] resp;
    logic [7:0]  exp;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) do_sample(16'($urandom), 16'h1234, 16'hFEDC, 16'($urandom), 16'h0100, 16'h3FFF);
      else do_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk);
      n_total++;
      if (INT !== 1'b1 || m_int() !== 1'b1) $display("FAIL burst_int_set: got %b want 1", INT);
      else n_pass++;
      frame(16'h0022 | 16'h8000, resp);
      frame(16'h2299, resp);
      for (int a = 'h22; a <= 'h2D; a++) begin
        exp = m_read(7'(a));
        frame({1'b1, 7'(a), 8'h00}, resp);
        n_total++;
        if (resp !== {8'h00, exp}) $display("FAIL burst_read %h: got %h want %h", a, resp, {8'h00, exp});
        else n_pass++;
        if (a == 'h22) begin
          n_total++;
          if (INT !== m_int()) $display("FAIL burst_int_clear: got %b want %b", INT, m_int());
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_coherence();
    logic [15:0] resp;
    logic [7:0]  exp;
    do_sample(16'($urandom), 16'h1234, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    frame(16'hA400, resp);
    do_sample(16'($urandom), 16'h5555, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    exp = m_read(7'h25);
    frame(16'hA500, resp);
    n_total++;
    if (resp !== {8'h00, exp} || exp !== 8'h12) $display("FAIL coherent_old: got %h want 0012", resp);
    else n_pass++;
    exp = m_read(7'h2D);
    frame(16'hAD00, resp);
    n_total++;
    if (resp !== {8'h00, exp}) $display("FAIL coherent_2d: got %h want %h", resp, {8'h00, exp});
    else n_pass++;
    n_total++;
    if (INT !== 1'b1 || m_int() !== 1'b1) $display("FAIL pending_int: got %b want 1", INT);
    else n_pass++;
    for (int a = 'h22; a <= 'h2D; a++) begin
      exp = m_read(7'(a));
      frame({1'b1, 7'(a), 8'h00}, resp);
      n_total++;
      if (resp !== {8'h00, exp}) $display("FAIL pending_read %h: got %h want %h", a, resp, {8'h00, exp});
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [15:0] resp;
    logic [7:0]  exp;
    do_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    @(negedge clk);
    spi_frame(16'h1077, 10, resp);
    n_total++;
    if (cfg_xl !== mc_xl) $display("FAIL abort_write: got %h want %h", cfg_xl, mc_xl);
    else n_pass++;
    spi_frame(16'hA400, 10, resp);
    n_total++;
    if (INT !== 1'b1 || m_int() !== 1'b1) $display("FAIL abort_read_int: got %b want 1", INT);
    else n_pass++;
    exp = m_read(7'h2D);
    frame(16'hAD00, resp);
    n_total++;
    if (resp !== {8'h00, exp}) $display("FAIL after_abort: got %h want %h", resp, {8'h00, exp});
    else n_pass++;
  endtask

  task automatic test_int_mask();
    logic [15:0] resp;
    frame(16'h0D00, resp);
    do_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    repeat (3) @(negedge clk);
    n_total++;
    if (INT !== 1'b0 || m_int() !== 1'b0) $display("FAIL int_masked: got %b want 0", INT);
    else n_pass++;
    frame(16'h0D02, resp);
    n_total++;
    if (INT !== 1'b1 || m_int() !== 1'b1) $display("FAIL int_unmasked: got %b want 1", INT);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] resp;
    @(negedge clk); SS_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      SCLK = 1'b0; MOSI = (i == 0 || (i >= 4 && i <= 7)) ? 1'b1 : 1'b0;
      repeat (5) @(negedge clk);
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
    end
    SCLK = 1'b0;
    repeat (5) @(negedge clk);
    n_total++;
    if (MISO !== 1'b1) $display("FAIL mid_frame_miso: got %b want 1", MISO);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({INT, MISO, cfg_int1, cfg_xl, cfg_g, cfg_c14} !== 34'h0)
      $display("FAIL mid_reset: got %b %b %h want 0 0 00000000", INT, MISO, {cfg_int1, cfg_xl, cfg_g, cfg_c14});
    else n_pass++;
    SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    frame(16'h8F00, resp);
    n_total++;
    if (resp !== 16'h006A) $display("FAIL post_reset_whoami: got %h want 006a", resp);
    else n_pass++;
    frame(16'h8D00, resp);
    n_total++;
    if (resp !== {8'h00, m_read(7'h0D)}) $display("FAIL post_reset_cfg: got %h want 0000", resp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_config();
    test_whoami();
    test_burst();
    test_coherence();
    test_abort();
    test_int_mask();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imu_spi_serf.md
Name: imu_spi_serf

Overview:
Synthesizable SPI responder that models the inertial sensor seen by the inertial interface block. It is used for FPGA emulation and closed-loop benches of the inclination path. It accepts 16-bit SPI frames: register writes for configuration, and register reads of gyro and accelerometer data. It raises INT when a new sample is available and keeps multi-byte burst reads coherent.

Parameters:
WHO_AM_I, 8'h6A, read-only ID value returned at address 0x0F.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
SS_n  in  1  SPI select, active-low, from initiator
SCLK  in  1  SPI clock, idle high, from initiator
MOSI  in  1  SPI data in, MSB first
MISO  out  1  SPI data out, MSB first
INT  out  1  data-ready interrupt, active-high level
smpl_vld  in  1  one-clk strobe: new sample present on data inputs
pitch_rt, roll_rt, yaw_rt, AX, AY, AZ  in  16 each  signed sample values
cfg_int1, cfg_xl, cfg_g, cfg_c14  out  8 each  current contents of config registers 0x0D/0x10/0x11/0x14

Behaviour:
Reset values:
- All config registers 0x00.
- Data registers 0x0000.
- INT=0, MISO=0; lock, pending and int_flag cleared.

Front end:
- SS_n, SCLK and MOSI are each double-flopped, with edge detect on synced SCLK and SS_n.
- SCLK high and low phases must each be ≥4 clk.

Frame format:
- bit15 = R/W (1 = read); bits14:8 = addr; bits7:0 = wdata (writes) or don't-care (reads).
- MOSI is sampled on SCLK rise; MISO changes on SCLK fall.

Frame sequence:
- SS_n fall: bit counter cleared; tx shift cleared, so MISO=0 for bits 15:8.
- After the 8th rise: latch R/W and addr. On a read, load tx shift with reg[addr] so bit7 appears on the following SCLK fall.
- After the 16th rise: on a write, capture wdata.
- SS_n rise ends the frame:
  - Frame is valid only if exactly 16 rises were counted.
  - Side effects (register write, INT clear, lock changes) are committed only on a valid frame, in the clk after the synced SS_n rise.
  - An invalid frame commits nothing.
- MISO returns to 0 while SS_n is high.

Register map:
- 0x0D INT1_CTRL rw; bit1 enables INT.
- 0x0F WHO_AM_I ro.
- 0x10 CTRL1_XL rw.
- 0x11 CTRL2_G rw.
- 0x14 CTRL_14 rw.
- 0x22/23 pitch L/H, 0x24/25 roll L/H, 0x26/27 yaw L/H, 0x28/29 AX L/H, 0x2A/2B AY L/H, 0x2C/2D AZ L/H; all ro.
- Unmapped addresses read 0x00. Writes to ro or unmapped addresses are ignored.

Sample path:
- smpl_vld while unlocked: all six data registers load in the next clk; int_flag set.
- smpl_vld while locked: the sample goes to a single pending buffer; a newer sample overwrites it.
- INT = int_flag & INT1_CTRL[1], registered. Clearing bit1 drops INT in the next clk; int_flag is retained.

Lock and INT clear:
- A valid read of any address 0x22–0x2C clears int_flag and sets lock.
- A valid read of 0x2D clears int_flag and releases lock. If a pending sample exists, it loads in the next clk and int_flag is set.
- Release in the same cycle as smpl_vld: the incoming sample loads directly; pending is discarded.
- A write to a data address does not affect lock.

Reset mid-frame:
- All state returns to reset values immediately.
- The frame is discarded; the next SS_n fall starts a fresh frame.

Test Plan:
- Write 0x0D02, 0x1053, 0x1150, 0x1460 -> cfg_int1=02, cfg_xl=53, cfg_g=50, cfg_c14=60; reads 0x8D00/0x9000 -> MISO byte 0x02/0x53, first byte 0x00.
- Read 0x8F00 -> resp[7:0]=0x6A. Write 0x0F55, then read 0x8F00 -> still 0x6A. Read unmapped 0xFF00 -> 0x00.
- cfg_int1=02; smpl_vld with roll=0x1234, yaw=0xFEDC, AY=0x0100, AZ=0x3FFF -> INT=1 within 2 clk. Reads A4..AD -> bytes 34,12,DC,FE,00,01,FF,3F; INT=0 after the 0xA400 frame ends.
- After reading 0xA400, smpl_vld with roll=0x5555 -> reading 0xA500 returns 0x12 (old); after 0xAD00 ends -> registers = new sample, INT=1.
- SS_n raised after 10 SCLK rises of write 0x1077 -> cfg_xl unchanged. With INT=1, aborted read of 0xA400 -> INT stays 1.
- cfg_int1=00 with smpl_vld -> INT=0. Then write 0x0D02 -> INT=1 (int_flag retained). Assert rst_n low mid-frame -> INT=0, MISO=0, cfg_* = 0.
